// File: rtl/fifo_pkg.sv
// Shared helpers for the BRAM FIFO family: width sizing and flag threshold arithmetic.
package fifo_pkg;

  function automatic int unsigned clog2w(input int unsigned value);
    int unsigned width;
    int unsigned rem;
    width = 0;
    rem   = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      width = width + 1;
      rem   = rem >> 1;
    end
    return (width == 0) ? 1 : width;
  endfunction

  // Occupancy at which almost-full asserts, leaving GRACE_PERIOD slots for in-flight writes.
  function automatic int unsigned af_level(input int unsigned depth, input int unsigned grace);
    return depth - grace;
  endfunction

endpackage

// File: rtl/fifo_bram_mem.sv
// Simple dual-port RAM: one write port, one read port registered on the next read address.
// Read-during-write to the same address returns the old word; the controller bypasses that case.
module fifo_bram_mem #(
  parameter     MEM_STYLE  = "auto",
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] rnext_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  (* ram_style = MEM_STYLE *)
  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    q_q <= mem_q[rnext_i];
  end

  assign q_o = q_q;

endmodule

// File: rtl/fifo_bram_ctrl.sv
// FWFT FIFO on block RAM with registered flags/count; first word visible two cycles after push.
// if_full_n gates writes, if_almost_full_n leaves GRACE_PERIOD slots; clear flushes without touching RAM.
module fifo_bram_ctrl
  import fifo_pkg::*;
#(
  parameter     MEM_STYLE    = "auto",
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 32,
  parameter int GRACE_PERIOD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_clear,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_count
);

  localparam int unsigned           AfInt           = af_level(DEPTH, GRACE_PERIOD);
  localparam logic [ADDR_WIDTH-1:0] DepthM1         = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DepthW          = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AlmostFullLevel = (ADDR_WIDTH + 1)'(AfInt);
  localparam logic                  AfullNRst       = (AlmostFullLevel != '0);

  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH:0]   used_q, used_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_n_q, full_n_d;
  logic                  afull_n_q, afull_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  show_ahead_q, show_ahead_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] bypass_q, bypass_d;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_nonempty;
  logic                  push;
  logic                  pop;
  logic                  consume;

  // Clear wins over both ports, so a write presented with it never reaches the RAM.
  always_comb begin
    ram_nonempty = (used_q != '0);
    push         = full_n_q & if_write_ce & if_write & ~if_clear;
    pop          = ram_nonempty & if_read_ce & (~empty_n_q | if_read) & ~if_clear;
    consume      = empty_n_q & if_read_ce & if_read;
  end

  always_comb begin
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    used_d       = used_q;
    empty_n_d    = empty_n_q;
    dout_d       = dout_q;
    bypass_d     = bypass_q;
    show_ahead_d = 1'b0;

    if (push) begin
      waddr_d  = (waddr_q == DepthM1) ? '0 : waddr_q + 1'b1;
      bypass_d = if_din;
    end
    if (pop) begin
      raddr_d = (raddr_q == DepthM1) ? '0 : raddr_q + 1'b1;
    end

    if (push && !pop) begin
      used_d = used_q + 1'b1;
    end else if (pop && !push) begin
      used_d = used_q - 1'b1;
    end

    // The RAM read register sees the old word when this push targets the next read address.
    show_ahead_d = push & (used_q == {{ADDR_WIDTH{1'b0}}, pop});

    if (pop) begin
      dout_d    = show_ahead_q ? bypass_q : ram_q;
      empty_n_d = 1'b1;
    end else if (consume) begin
      empty_n_d = 1'b0;
    end

    if (if_clear) begin
      waddr_d      = '0;
      raddr_d      = '0;
      used_d       = '0;
      empty_n_d    = 1'b0;
      show_ahead_d = 1'b0;
    end

    full_n_d  = (used_d != DepthW);
    afull_n_d = (used_d < AlmostFullLevel);
    count_d   = used_d + {{ADDR_WIDTH{1'b0}}, empty_n_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q      <= '0;
      raddr_q      <= '0;
      used_q       <= '0;
      count_q      <= '0;
      full_n_q     <= 1'b1;
      afull_n_q    <= AfullNRst;
      empty_n_q    <= 1'b0;
      show_ahead_q <= 1'b0;
      dout_q       <= '0;
      bypass_q     <= '0;
    end else begin
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      used_q       <= used_d;
      count_q      <= count_d;
      full_n_q     <= full_n_d;
      afull_n_q    <= afull_n_d;
      empty_n_q    <= empty_n_d;
      show_ahead_q <= show_ahead_d;
      dout_q       <= dout_d;
      bypass_q     <= bypass_d;
    end
  end

  fifo_bram_mem #(
    .MEM_STYLE  (MEM_STYLE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (waddr_q),
    .wdata_i (if_din),
    .rnext_i (raddr_d),
    .q_o     (ram_q)
  );

  assign if_full_n        = full_n_q;
  assign if_almost_full_n = afull_n_q;
  assign if_empty_n       = empty_n_q;
  assign if_dout          = dout_q;
  assign if_count         = count_q;

endmodule
